systolic_drain_deskew: RTL and testbench

//  Output-side realigner for the MxN weight-stationary systolic array. Accumulator columns emit

---
 rtl/systolic_drain_deskew_if.sv | 32 +++
 rtl/systolic_drain_deskew.sv | 115 +++++++++++
 tb/tb_systolic_drain_deskew.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_drain_deskew_if.sv
// Stream bundle between the systolic drain deskew block and its producer/consumer.
// Lane width defaults to `C_WIDTH (32 when the macro is not provided).
`ifndef C_WIDTH
`define C_WIDTH 32
`endif

interface systolic_drain_deskew_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = `C_WIDTH,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [N-1:0][DW-1:0] psum_in;
  logic [N-1:0]         valid_in;
  logic [N-1:0][DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LW-1:0]        level;
  logic                 overflow;
  logic                 skew_err;

  modport master (
    output psum_in, valid_in, out_ready,
    input  out_data, out_valid, level, overflow, skew_err
  );

  modport slave (
    input  psum_in, valid_in, out_ready,
    output out_data, out_valid, level, overflow, skew_err
  );
endinterface

// File: rtl/systolic_drain_deskew.sv
// Realigns skewed systolic-array column results into whole rows and buffers them in a FIFO.
// Optional feature: define DRAIN_RELU_EN to clamp negative lanes to 0 at FIFO write.
`ifndef C_WIDTH
`define C_WIDTH 32
`endif

module systolic_drain_deskew #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = `C_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  systolic_drain_deskew_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef logic [N-1:0][DW-1:0] row_t;

  row_t         dsk_data;
  logic [N-1:0] dsk_valid;

  // Lane j is delayed N-1-j cycles so that every lane lines up with the last column.
  for (genvar j = 0; j < int'(N); j++) begin : g_lane
    localparam int unsigned S = N - 1 - j;
    if (S == 0) begin : g_direct
      assign dsk_data[j]  = bus.psum_in[j];
      assign dsk_valid[j] = bus.valid_in[j];
    end else begin : g_dly
      logic [DW-1:0] sd [S];
      logic [S-1:0]  sv;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < int'(S); k++) sd[k] <= '0;
          sv <= '0;
        end else begin
          sd[0] <= bus.psum_in[j];
          sv[0] <= bus.valid_in[j];
          for (int k = 1; k < int'(S); k++) begin
            sd[k] <= sd[k-1];
            sv[k] <= sv[k-1];
          end
        end
      end

      assign dsk_data[j]  = sd[S-1];
      assign dsk_valid[j] = sv[S-1];
    end
  end

  row_t wdata;

  always_comb begin
    wdata = dsk_data;
`ifdef DRAIN_RELU_EN
    for (int j = 0; j < int'(N); j++) begin
      if (dsk_data[j][DW-1]) wdata[j] = '0;
    end
`endif
  end

  row_t          mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic          skew_q;

  logic row_full;
  logic row_any;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    row_full = &dsk_valid;
    row_any  = |dsk_valid;
    full     = (level_q == LW'(DEPTH));
    pop      = (level_q != '0) && bus.out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push     = row_full && (!full || pop);
    drop     = row_full && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      skew_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
      if (drop) ovf_q <= 1'b1;
      if (row_any && !row_full) skew_q <= 1'b1;
    end
  end

  assign bus.out_data  = mem[rptr];
  assign bus.out_valid = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;
  assign bus.skew_err  = skew_q;

endmodule

// File: tb/tb_systolic_drain_deskew.sv
// Directed scoreboard bench for systolic_drain_deskew (N=2, DW=32, DEPTH=4).
`timescale 1ns/1ps

module tb_systolic_drain_deskew;
  typedef logic [1:0][31:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_drain_deskew_if #(.N(2), .DW(32), .DEPTH(4)) bus ();

  systolic_drain_deskew #(.N(2), .DW(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  row_t q[$];
  bit   exp_ovf  = 1'b0;
  bit   exp_skew = 1'b0;

  function automatic row_t mk(input logic [31:0] a, input logic [31:0] b);
    row_t r;
    r[0] = a;
    r[1] = b;
    return r;
  endfunction

  function automatic row_t fix(input row_t r);
    row_t o;
    o = r;
`ifdef DRAIN_RELU_EN
    for (int i = 0; i < 2; i++) if (o[i][31]) o[i] = '0;
`endif
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    bus.valid_in[0] = v0;
    bus.psum_in[0]  = v0 ? d0 : 32'd0;
    bus.valid_in[1] = v1;
    bus.psum_in[1]  = v1 ? d1 : 32'd0;
  endtask

  // kind: 0 = no row completes, 1 = full row completes, 2 = partial row after deskew
  task automatic tick(input string tag, input int kind, input row_t r);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(q.size() != 0));
    chk({tag, "_level"}, 64'(bus.level), 64'(q.size()));
    chk({tag, "_ovf"},   64'(bus.overflow), 64'(exp_ovf));
    chk({tag, "_skew"},  64'(bus.skew_err), 64'(exp_skew));
    if (q.size() != 0) begin
      chk({tag, "_data"}, 64'(bus.out_data), 64'(q[0]));
      if (bus.out_ready) void'(q.pop_front());
    end
    if (kind == 1) begin
      if (q.size() < 4) q.push_back(fix(r));
      else exp_ovf = 1'b1;
    end else if (kind == 2) begin
      exp_skew = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drv(0, 0, 0, 0);
    q.delete();
    exp_ovf  = 1'b0;
    exp_skew = 1'b0;
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data), 64'd0);
    chk("rst_ovf",   64'(bus.overflow), 64'd0);
    chk("rst_skew",  64'(bus.skew_err), 64'd0);
  endtask

  initial begin
    row_t z;
    z = '0;
    bus.out_ready = 1'b0;
    drv(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    tick("idle", 0, z);

    // single row {5,7}, one cycle of latency after lane 1
    bus.out_ready = 1'b1;
    drv(1, 5, 0, 0);      tick("s1a", 0, z);
    drv(0, 0, 1, 7);      tick("s1b", 1, mk(5, 7));
    drv(0, 0, 0, 0);      tick("s1c", 0, z);
    chk("s1_after", 64'(bus.out_valid), 64'd0);
    tick("s1d", 0, z);

    // backpressure with five rows into a 4-deep FIFO
    bus.out_ready = 1'b0;
    drv(1, 1, 0, 0);      tick("bp0", 0, z);
    for (int k = 1; k <= 4; k++) begin
      drv(1, 32'(k + 1), 1, 32'(k));
      tick("bp", 1, mk(32'(k), 32'(k)));
    end
    drv(0, 0, 1, 5);      tick("bp5", 1, mk(5, 5));
    drv(0, 0, 0, 0);      tick("bp_hold", 0, z);
    chk("bp_full", 64'(bus.level), 64'd4);
    chk("bp_ovf", 64'(bus.overflow), 64'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick("bp_drain", 0, z);
    chk("bp_empty", 64'(bus.level), 64'd0);

    // full FIFO with push and pop in the same cycle
    do_reset();
    bus.out_ready = 1'b0;
    drv(1, 1, 0, 0);      tick("fp0", 0, z);
    for (int k = 1; k <= 3; k++) begin
      drv(1, 32'(k + 1), 1, 32'(k));
      tick("fp", 1, mk(32'(k), 32'(k)));
    end
    drv(1, 9, 1, 4);      tick("fp4", 1, mk(4, 4));
    bus.out_ready = 1'b1;
    drv(0, 0, 1, 9);      tick("fp9", 1, mk(9, 9));
    drv(0, 0, 0, 0);
    chk("fp_level", 64'(bus.level), 64'd4);
    chk("fp_ovf", 64'(bus.overflow), 64'd0);
    for (int k = 0; k < 5; k++) tick("fp_drain", 0, z);

    // skew error: lane 0 without lane 1
    do_reset();
    drv(1, 32'h11, 0, 0); tick("sk0", 0, z);
    drv(0, 0, 0, 0);      tick("sk1", 2, z);
    tick("sk2", 0, z);
    chk("sk_flag", 64'(bus.skew_err), 64'd1);
    chk("sk_level", 64'(bus.level), 64'd0);

    // reset with three rows buffered and one lane-0 sample in flight
    do_reset();
    bus.out_ready = 1'b0;
    drv(1, 1, 0, 0);          tick("mr0", 0, z);
    drv(1, 2, 1, 1);          tick("mr1", 1, mk(1, 1));
    drv(1, 3, 1, 2);          tick("mr2", 1, mk(2, 2));
    drv(1, 32'hAA, 1, 3);     tick("mr3", 1, mk(3, 3));
    chk("mr_level", 64'(bus.level), 64'd3);
    drv(0, 0, 1, 32'hBB);
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick("mr_post", 0, z);

    // negative lane value, clamped only when ReLU is built in
    drv(1, 32'hFFFF_FFFD, 0, 0); tick("rl0", 0, z);
    drv(0, 0, 1, 4);             tick("rl1", 1, mk(32'hFFFF_FFFD, 4));
    drv(0, 0, 0, 0);             tick("rl2", 0, z);
    tick("rl3", 0, z);

    // back-to-back stream at full rate
    drv(1, 32'h100, 0, 0); tick("bb0", 0, z);
    for (int k = 1; k <= 6; k++) begin
      drv(1, 32'(32'h100 + k), 1, 32'(32'h200 + k - 1));
      tick("bb", 1, mk(32'(32'h100 + k - 1), 32'(32'h200 + k - 1)));
    end
    drv(0, 0, 1, 32'h206); tick("bb7", 1, mk(32'h106, 32'h206));
    drv(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick("bb_drain", 0, z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
